// File: rtl/dseg_wr_arbiter.sv
// Round-robin write arbiter for a shared 7-segment display register.
// After each granted write the display is held for HOLD_CYCLES cycles before the next grant.
//
// state | meaning
// IDLE  | sample req, grant the round-robin winner unless frozen
// WRITE | one-cycle EN/ack pulse for the granted requester
// HOLD  | display locked, counting up to HOLD_CYCLES-1
module dseg_wr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] data_i0,
    input  logic [31:0] data_i1,
    input  logic [31:0] data_i2,
    input  logic [31:0] data_i3,
    input  logic [7:0]  blink_i0,
    input  logic [7:0]  blink_i1,
    input  logic [7:0]  blink_i2,
    input  logic [7:0]  blink_i3,
    input  logic [7:0]  point_i0,
    input  logic [7:0]  point_i1,
    input  logic [7:0]  point_i2,
    input  logic [7:0]  point_i3,
    input  logic        freeze,
    output logic        EN,
    output logic [31:0] Data0,
    output logic [7:0]  les_out,
    output logic [7:0]  point_out,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [1:0]  cur_ch
);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    state_t      state;
    logic [31:0] hold_cnt;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        found;
    logic [31:0] sel_data;
    logic [7:0]  sel_blink;
    logic [7:0]  sel_point;

    // Search begins one past the last grant; i=4 wraps back onto cur_ch itself.
    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = cur_ch + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data  = data_i0;
        sel_blink = blink_i0;
        sel_point = point_i0;
        case (win)
            2'd1: begin
                sel_data  = data_i1;
                sel_blink = blink_i1;
                sel_point = point_i1;
            end
            2'd2: begin
                sel_data  = data_i2;
                sel_blink = blink_i2;
                sel_point = point_i2;
            end
            2'd3: begin
                sel_data  = data_i3;
                sel_blink = blink_i3;
                sel_point = point_i3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            EN        <= 1'b0;
            ack       <= 4'b0000;
            busy      <= 1'b0;
            Data0     <= 32'h0;
            les_out   <= 8'h00;
            point_out <= 8'h00;
            cur_ch    <= 2'd3;
            hold_cnt  <= 32'd0;
        end else begin
            EN  <= 1'b0;
            ack <= 4'b0000;
            case (state)
                IDLE: begin
                    if (req != 4'b0000 && !freeze) begin
                        Data0     <= sel_data;
                        les_out   <= sel_blink;
                        point_out <= sel_point;
                        cur_ch    <= win;
                        EN        <= 1'b1;
                        ack       <= 4'b0001 << win;
                        busy      <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    hold_cnt <= 32'd0;
                    if (HOLD_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= HOLD;
                        busy  <= 1'b1;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 32'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dseg_wr_arbiter.sv
// Directed bench for dseg_wr_arbiter: three instances (HOLD_CYCLES = 4, 0, 100) share stimulus;
// each scenario resets all of them and checks the instance whose hold length it needs.
module tb_dseg_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_i0, data_i1, data_i2, data_i3;
    logic [7:0]  blink_i0, blink_i1, blink_i2, blink_i3;
    logic [7:0]  point_i0, point_i1, point_i2, point_i3;
    logic        freeze;

    logic        en_4, en_0, en_100;
    logic [31:0] data0_4, data0_0, data0_100;
    logic [7:0]  les_4, les_0, les_100;
    logic [7:0]  pnt_4, pnt_0, pnt_100;
    logic [3:0]  ack_4, ack_0, ack_100;
    logic        busy_4, busy_0, busy_100;
    logic [1:0]  ch_4, ch_0, ch_100;

    int checks = 0;
    int errors = 0;

    logic [3:0]  rot_ack  [5];
    logic [31:0] rot_data [5];

    dseg_wr_arbiter #(.HOLD_CYCLES(4)) u_h4 (
        .clk(clk), .rst(rst), .req(req),
        .data_i0(data_i0), .data_i1(data_i1), .data_i2(data_i2), .data_i3(data_i3),
        .blink_i0(blink_i0), .blink_i1(blink_i1), .blink_i2(blink_i2), .blink_i3(blink_i3),
        .point_i0(point_i0), .point_i1(point_i1), .point_i2(point_i2), .point_i3(point_i3),
        .freeze(freeze), .EN(en_4), .Data0(data0_4), .les_out(les_4), .point_out(pnt_4),
        .ack(ack_4), .busy(busy_4), .cur_ch(ch_4)
    );

    dseg_wr_arbiter #(.HOLD_CYCLES(0)) u_h0 (
        .clk(clk), .rst(rst), .req(req),
        .data_i0(data_i0), .data_i1(data_i1), .data_i2(data_i2), .data_i3(data_i3),
        .blink_i0(blink_i0), .blink_i1(blink_i1), .blink_i2(blink_i2), .blink_i3(blink_i3),
        .point_i0(point_i0), .point_i1(point_i1), .point_i2(point_i2), .point_i3(point_i3),
        .freeze(freeze), .EN(en_0), .Data0(data0_0), .les_out(les_0), .point_out(pnt_0),
        .ack(ack_0), .busy(busy_0), .cur_ch(ch_0)
    );

    dseg_wr_arbiter #(.HOLD_CYCLES(100)) u_h100 (
        .clk(clk), .rst(rst), .req(req),
        .data_i0(data_i0), .data_i1(data_i1), .data_i2(data_i2), .data_i3(data_i3),
        .blink_i0(blink_i0), .blink_i1(blink_i1), .blink_i2(blink_i2), .blink_i3(blink_i3),
        .point_i0(point_i0), .point_i1(point_i1), .point_i2(point_i2), .point_i3(point_i3),
        .freeze(freeze), .EN(en_100), .Data0(data0_100), .les_out(les_100), .point_out(pnt_100),
        .ack(ack_100), .busy(busy_100), .cur_ch(ch_100)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; freeze = 1'b0;
        data_i0 = 32'hCAFEF00D; data_i1 = 32'h0BADBEEF; data_i2 = 32'h12345678; data_i3 = 32'hDEADC0DE;
        blink_i0 = 8'h01; blink_i1 = 8'h02; blink_i2 = 8'hA5; blink_i3 = 8'h08;
        point_i0 = 8'h10; point_i1 = 8'h20; point_i2 = 8'h3C; point_i3 = 8'h80;
        rot_ack[0] = 4'b0001; rot_ack[1] = 4'b0010; rot_ack[2] = 4'b0100; rot_ack[3] = 4'b1000; rot_ack[4] = 4'b0001;
        rot_data[0] = 32'hCAFEF00D; rot_data[1] = 32'h0BADBEEF; rot_data[2] = 32'h12345678;
        rot_data[3] = 32'hDEADC0DE; rot_data[4] = 32'hCAFEF00D;

        // Reset held two cycles with all requests high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_en", {31'd0, en_4}, 32'd0);
            check("rst_ack", {28'd0, ack_4}, 32'd0);
            check("rst_busy", {31'd0, busy_4}, 32'd0);
            check("rst_data", data0_4, 32'd0);
            check("rst_les", {24'd0, les_4}, 32'd0);
            check("rst_point", {24'd0, pnt_4}, 32'd0);
            check("rst_cur_ch", {30'd0, ch_4}, 32'd3);
        end

        // Single request, HOLD_CYCLES=4
        rst = 1'b0; req = 4'b0100;
        @(negedge clk);
        check("single_en", {31'd0, en_4}, 32'd1);
        check("single_ack", {28'd0, ack_4}, 32'b0100);
        check("single_data", data0_4, 32'h12345678);
        check("single_les", {24'd0, les_4}, 32'hA5);
        check("single_point", {24'd0, pnt_4}, 32'h3C);
        check("single_cur_ch", {30'd0, ch_4}, 32'd2);
        check("single_busy", {31'd0, busy_4}, 32'd1);
        req = 4'b0001;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check("hold_busy", {31'd0, busy_4}, 32'd1);
            check("hold_en", {31'd0, en_4}, 32'd0);
            check("hold_ack", {28'd0, ack_4}, 32'd0);
        end
        @(negedge clk);
        check("idle_busy", {31'd0, busy_4}, 32'd0);
        check("idle_en", {31'd0, en_4}, 32'd0);
        check("data_stable", data0_4, 32'h12345678);
        @(negedge clk);
        check("next_en", {31'd0, en_4}, 32'd1);
        check("next_ack", {28'd0, ack_4}, 32'b0001);
        check("next_data", data0_4, 32'hCAFEF00D);
        req = 4'b0000;

        // Rotation with HOLD_CYCLES=0
        req = 4'b1111;
        do_reset(1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("rot_en", {31'd0, en_0}, 32'd1);
            check("rot_ack", {28'd0, ack_0}, {28'd0, rot_ack[n]});
            check("rot_data", data0_0, rot_data[n]);
            @(negedge clk);
            check("rot_gap_en", {31'd0, en_0}, 32'd0);
            check("rot_gap_busy", {31'd0, busy_0}, 32'd0);
        end

        // Pointer: grant ch1, then req=1001 goes to ch3 before ch0
        req = 4'b0010;
        do_reset(1);
        @(negedge clk);
        check("rr_first", {28'd0, ack_0}, 32'b0010);
        req = 4'b1001;
        @(negedge clk);
        check("rr_gap", {31'd0, en_0}, 32'd0);
        @(negedge clk);
        check("rr_ch3", {28'd0, ack_0}, 32'b1000);
        @(negedge clk);
        @(negedge clk);
        check("rr_ch0", {28'd0, ack_0}, 32'b0001);
        req = 4'b0000;

        // Freeze with req[0] pending, HOLD_CYCLES=4
        do_reset(1);
        freeze = 1'b1; req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("frz_en", {31'd0, en_4}, 32'd0);
            check("frz_busy", {31'd0, busy_4}, 32'd0);
        end
        freeze = 1'b0;
        @(negedge clk);
        check("frz_release_en", {31'd0, en_4}, 32'd1);
        check("frz_release_ack", {28'd0, ack_4}, 32'b0001);
        freeze = 1'b1; req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("frz_hold_busy", {31'd0, busy_4}, 32'd1);
        end
        @(negedge clk);
        check("frz_hold_done", {31'd0, busy_4}, 32'd0);
        freeze = 1'b0;

        // Reset in the WRITE cycle must not leave a late ack
        req = 4'b0010;
        do_reset(1);
        @(negedge clk);
        check("wr_rst_pre", {28'd0, ack_4}, 32'b0010);
        rst = 1'b1; req = 4'b0000;
        @(negedge clk);
        check("wr_rst_ack", {28'd0, ack_4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("wr_rst_ack2", {28'd0, ack_4}, 32'd0);
        check("wr_rst_busy", {31'd0, busy_4}, 32'd0);

        // Reset 20 cycles into HOLD, HOLD_CYCLES=100
        req = 4'b0100;
        do_reset(1);
        @(negedge clk);
        check("h100_grant", {28'd0, ack_100}, 32'b0100);
        req = 4'b0000;
        repeat (21) @(negedge clk);
        check("h100_in_hold", {31'd0, busy_100}, 32'd1);
        rst = 1'b1; req = 4'b1010;
        @(negedge clk);
        check("h100_rst_busy", {31'd0, busy_100}, 32'd0);
        check("h100_rst_ch", {30'd0, ch_100}, 32'd3);
        check("h100_rst_data", data0_100, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("h100_next_en", {31'd0, en_100}, 32'd1);
        check("h100_next_ack", {28'd0, ack_100}, 32'b0010);
        req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
